hdr_pattern_detector: RTL
=========================

Name: hdr_pattern_detector

Overview:
Parametrised I3C target-side detector for HDR Restart and HDR Exit patterns on the raw SCL/SDA pins, oversampled on i_sys_clk. It synchronises and glitch-filters both lines, then counts SDA falling edges inside a single SCL-low phase. Each completed pattern produces a one-cycle pulse to the HDR engine. It replaces the fixed-timing, level-sequence restart detector, and adds exit detection, filtering, a timeout and an enable.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line (min 2)
FILT_CYCLES, 2, consecutive identical synchronised samples required before the filtered value changes (min 1)
TIMEOUT_CYCLES, 1024, sys clocks without a filtered edge while a pattern is partially seen before abort; 0 disables the timeout
TO_W, $clog2(TIMEOUT_CYCLES+1), width of the timeout counter (derived, not overridden)

Ports:
i_sys_clk  in  1  system clock, oversamples SCL/SDA
i_sys_rst  in  1  asynchronous, active-low reset
i_enable  in  1  HDR mode active; when low the detector is held in IDLE
i_scl  in  1  raw SCL pin
i_sda  in  1  raw SDA pin
o_restart_det  out  1  one-cycle pulse: HDR Restart detected
o_exit_det  out  1  one-cycle pulse: HDR Exit detected
o_timeout  out  1  one-cycle pulse: partial pattern aborted by the timeout
o_pattern_busy  out  1  high while in LOW with fall_cnt>=1, or in EXIT_HOLD
o_sda_fall_cnt  out  3  SDA falls counted in the current SCL-low phase, saturates at 4

Behaviour:
- Reset:
  - Synchroniser flops and filtered scl_f/sda_f reset to 1 (idle bus).
  - State = IDLE; all counters = 0; all outputs = 0.
- Filter:
  - Each line passes through SYNC_STAGES flops, then a stability counter.
  - scl_f/sda_f update only after FILT_CYCLES consecutive equal samples that differ from the current filtered value.
  - Pin-to-filtered latency is SYNC_STAGES+FILT_CYCLES clocks.
  - Shorter pulses are discarded.
- Edge flags: registered compare of scl_f/sda_f against their previous values, giving scl_rise, scl_fall and sda_fall.
- States:
  - IDLE
    - Entered on scl_fall while i_enable=1.
    - Action: go to LOW, fall_cnt=0.
  - LOW
    - sda_fall: fall_cnt++.
    - When fall_cnt reaches 4: o_exit_det=1 in the next cycle; go to EXIT_HOLD.
    - scl_rise with fall_cnt==2 and previous-cycle sda_f==1: o_restart_det pulse, go to IDLE.
    - scl_rise with any other count (0, 1, 3): no pulse, go to IDLE. Counts 0 and 1 are normal DDR traffic; 3 is malformed.
  - EXIT_HOLD
    - Further SDA activity is ignored.
    - When scl_f==1 and sda_f==1 (STOP completed): go to IDLE.
- Pulse timing: o_restart_det and o_exit_det assert exactly one clock after the qualifying filtered edge and last one cycle.
- Simultaneous events:
  - scl_rise and sda_fall in the same cycle: the SCL edge wins and the fall is not counted.
  - The restart SDA check uses the value before the edge, so SDA rising together with SCL is not a restart.
- Timeout:
  - Counter runs in LOW while fall_cnt>=1 and clears on any filtered edge.
  - Reaching TIMEOUT_CYCLES: o_timeout pulse, go to IDLE.
  - Inactive in EXIT_HOLD and inactive when TIMEOUT_CYCLES=0.
- i_enable low:
  - Synchronous return to IDLE, counters cleared, no pulse.
  - The filter keeps running, so re-enabling needs no settling time.
- Reset mid-pattern: immediate IDLE; the next pattern is detected only after a fresh scl_fall.
- fall_cnt saturates at 4; o_sda_fall_cnt mirrors it and reads 0 in IDLE.

Decomposition:
- Shared I3C package holds:
  - the state enum (IDLE, LOW, EXIT_HOLD);
  - constants HDR_RESTART_FALLS=2 and HDR_EXIT_FALLS=4.
- One sub-module, i3c_line_filter (synchroniser plus stability filter, parameters SYNC_STAGES and FILT_CYCLES), instantiated once each for SCL and SDA.

Test Plan:
- Restart, FILT_CYCLES=2: SCL low; SDA 1→0→1→0→1, each level held 10 clk; then SCL rises → exactly one o_restart_det pulse, o_sda_fall_cnt=2 just before the pulse, no o_exit_det.
- Exit: SCL low; four SDA falls, levels held 10 clk; then STOP → o_exit_det pulses once, 1 clk after the 4th filtered fall; o_pattern_busy stays high until STOP, then drops.
- Glitch: 1-clk SDA low spikes during SCL low with FILT_CYCLES=2 → fall_cnt stays 0, no pulses.
- Normal DDR traffic: 20 SCL periods with one SDA change per phase → no pulses, o_pattern_busy toggles only with fall_cnt=1.
- Timeout, TIMEOUT_CYCLES=16: one SDA fall then idle for 20 clk → o_timeout pulses at the 16th idle clock, state returns to IDLE, the later SCL rise gives no restart.
- Abort cases: disable after 2 falls → no pulse; async reset after 3 falls → outputs 0 immediately; SDA and SCL rise in the same filtered cycle after 2 falls → no o_restart_det.

Source files
------------

// File: rtl/hdr_pattern_detector_pkg.sv
// Shared I3C HDR pattern-detection types and constants.
package hdr_pattern_detector_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    EXIT_HOLD = 2'd2
  } hdr_state_t;

  localparam logic [2:0] HDR_RESTART_FALLS = 3'd2;
  localparam logic [2:0] HDR_EXIT_FALLS    = 3'd4;

  // Edge flags of the filtered bus, one cycle behind the filtered edge.
  typedef struct packed {
    logic scl_rise;
    logic scl_fall;
    logic sda_fall;
    logic any;
  } bus_edge_t;

endpackage

// File: rtl/hdr_pattern_detector_line_filter.sv
// Synchroniser plus stability filter for one open-drain bus line.
module i3c_line_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 2
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  input  logic line_in,
  output logic line_f
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          stab_cnt;
  logic                   sync_out;

  assign sync_out = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      sync_q   <= '1;
      stab_cnt <= '0;
      line_f   <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_in};
      // Any sample matching the current filtered value restarts the run.
      if (sync_out == line_f) begin
        stab_cnt <= '0;
      end else if (stab_cnt == CW'(FILT_CYCLES-1)) begin
        line_f   <= sync_out;
        stab_cnt <= '0;
      end else begin
        stab_cnt <= stab_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hdr_pattern_detector.sv
// HDR Restart / HDR Exit detector: counts SDA falls within one filtered SCL-low phase.
module hdr_pattern_detector
  import hdr_pattern_detector_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILT_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int TO_W          = $clog2(TIMEOUT_CYCLES+1)
) (
  input  logic       i_sys_clk,
  input  logic       i_sys_rst,
  input  logic       i_enable,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_restart_det,
  output logic       o_exit_det,
  output logic       o_timeout,
  output logic       o_pattern_busy,
  output logic [2:0] o_sda_fall_cnt
);

  localparam int TCW = (TO_W > 0) ? TO_W : 1;

  logic       scl_f, sda_f, scl_f_d, sda_f_d;
  bus_edge_t  ev;
  hdr_state_t state, state_n;
  logic [2:0] fall_cnt, fall_n;
  logic [TCW-1:0] to_cnt, to_n;
  logic       restart_n, exit_n, timeout_n;

  i3c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_scl_filt (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .line_in   (i_scl),
    .line_f    (scl_f)
  );

  i3c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES)) u_sda_filt (
    .i_sys_clk (i_sys_clk),
    .i_sys_rst (i_sys_rst),
    .line_in   (i_sda),
    .line_f    (sda_f)
  );

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      scl_f_d <= 1'b1;
      sda_f_d <= 1'b1;
    end else begin
      scl_f_d <= scl_f;
      sda_f_d <= sda_f;
    end
  end

  assign ev.scl_rise = scl_f & ~scl_f_d;
  assign ev.scl_fall = ~scl_f & scl_f_d;
  assign ev.sda_fall = ~sda_f & sda_f_d;
  assign ev.any      = (scl_f ^ scl_f_d) | (sda_f ^ sda_f_d);

  always_comb begin
    state_n   = state;
    fall_n    = fall_cnt;
    to_n      = to_cnt;
    restart_n = 1'b0;
    exit_n    = 1'b0;
    timeout_n = 1'b0;
    if (!i_enable) begin
      state_n = IDLE;
      fall_n  = '0;
      to_n    = '0;
    end else begin
      case (state)
        IDLE: begin
          fall_n = '0;
          to_n   = '0;
          if (ev.scl_fall) state_n = LOW;
        end
        LOW: begin
          // SCL edge has priority; the restart check uses SDA from before the edge.
          if (ev.scl_rise) begin
            restart_n = (fall_cnt == HDR_RESTART_FALLS) && sda_f_d;
            state_n   = IDLE;
            fall_n    = '0;
            to_n      = '0;
          end else if (ev.sda_fall) begin
            to_n = '0;
            if (fall_cnt == HDR_EXIT_FALLS - 3'd1) begin
              fall_n  = HDR_EXIT_FALLS;
              exit_n  = 1'b1;
              state_n = EXIT_HOLD;
            end else begin
              fall_n = fall_cnt + 3'd1;
            end
          end else if (ev.any) begin
            to_n = '0;
          end else if (TIMEOUT_CYCLES > 0 && fall_cnt != 3'd0) begin
            if (to_cnt == TCW'(TIMEOUT_CYCLES-1)) begin
              timeout_n = 1'b1;
              state_n   = IDLE;
              fall_n    = '0;
              to_n      = '0;
            end else begin
              to_n = to_cnt + 1'b1;
            end
          end
        end
        EXIT_HOLD: begin
          if (scl_f && sda_f) begin
            state_n = IDLE;
            fall_n  = '0;
          end
        end
        default: begin
          state_n = IDLE;
          fall_n  = '0;
          to_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_sys_clk or negedge i_sys_rst) begin
    if (!i_sys_rst) begin
      state         <= IDLE;
      fall_cnt      <= '0;
      to_cnt        <= '0;
      o_restart_det <= 1'b0;
      o_exit_det    <= 1'b0;
      o_timeout     <= 1'b0;
    end else begin
      state         <= state_n;
      fall_cnt      <= fall_n;
      to_cnt        <= to_n;
      o_restart_det <= restart_n;
      o_exit_det    <= exit_n;
      o_timeout     <= timeout_n;
    end
  end

  assign o_pattern_busy = ((state == LOW) && (fall_cnt != 3'd0)) || (state == EXIT_HOLD);
  assign o_sda_fall_cnt = fall_cnt;

endmodule
